// File: rtl/aes192_key_unroll.sv
// AES-192 key schedule for the decrypt path. The key is expanded forward to chunk S8,
// then walked back with the inverse step so S8..S0 stream out without a 52-word store.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, t;
    p = '0;
    t = x;
    for (int b = 0; b < 8; b++) begin
      if (z[b]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq, inv;

  // Multiplicative inverse as a^254 (maps 0 to 0), then the AES affine transform.
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int b = 1; b < 8; b++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes192_key_unroll #(
  parameter int NUM_CHUNKS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [191:0] key_in,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_step,
  output logic [191:0] out_key,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

  state_t           st, st_nx;
  logic [191:0]     key_q, key_nx;
  logic [3:0]       cnt, cnt_nx;
  logic             done_nx;
  logic [5:0][31:0] w;
  logic [5:0][31:0] fwd, bwd;
  logic [31:0]      sub_in, rot_in, sub_out, rc;

  assign w = key_q;

  // One shared SubWord: forward uses o0 directly, inverse uses recovered o0 = n0 ^ n1.
  assign sub_in = (st == EMIT) ? (w[0] ^ w[1]) : w[0];
  assign rot_in = {sub_in[23:0], sub_in[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(rot_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
  end

  always_comb begin
    case (cnt)
      4'd1:    rc = 32'h0100_0000;
      4'd2:    rc = 32'h0200_0000;
      4'd3:    rc = 32'h0400_0000;
      4'd4:    rc = 32'h0800_0000;
      4'd5:    rc = 32'h1000_0000;
      4'd6:    rc = 32'h2000_0000;
      4'd7:    rc = 32'h4000_0000;
      4'd8:    rc = 32'h8000_0000;
      default: rc = 32'h0;
    endcase
  end

  always_comb begin
    fwd[5] = w[5] ^ sub_out ^ rc;
    fwd[4] = w[4] ^ fwd[5];
    fwd[3] = w[3] ^ fwd[4];
    fwd[2] = w[2] ^ fwd[3];
    fwd[1] = w[1] ^ fwd[2];
    fwd[0] = w[0] ^ fwd[1];
    bwd[0] = w[0] ^ w[1];
    bwd[1] = w[1] ^ w[2];
    bwd[2] = w[2] ^ w[3];
    bwd[3] = w[3] ^ w[4];
    bwd[4] = w[4] ^ w[5];
    bwd[5] = w[5] ^ sub_out ^ rc;
  end

  // cnt is the Rcon index i while expanding and the chunk index k while emitting.
  always_comb begin
    st_nx   = st;
    key_nx  = key_q;
    cnt_nx  = cnt;
    done_nx = 1'b0;
    case (st)
      IDLE: if (start) begin
        key_nx = key_in;
        cnt_nx = 4'd1;
        st_nx  = FWD;
      end
      FWD: begin
        key_nx = fwd;
        if (cnt == 4'(NUM_CHUNKS)) st_nx = EMIT;
        else                       cnt_nx = cnt + 4'd1;
      end
      EMIT: if (out_ready) begin
        if (cnt == 4'd0) begin
          st_nx   = IDLE;
          done_nx = 1'b1;
        end else begin
          key_nx = bwd;
          cnt_nx = cnt - 4'd1;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      key_q <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      st    <= st_nx;
      key_q <= key_nx;
      cnt   <= cnt_nx;
      done  <= done_nx;
    end
  end

  assign busy      = (st != IDLE);
  assign out_valid = (st == EMIT);
  assign out_key   = key_q;
  assign out_step  = cnt;
endmodule

// File: tb/tb_aes192_key_unroll.sv
// Directed bench for aes192_key_unroll against the FIPS-197 AES-192 expansion words.
module tb_aes192_key_unroll;
  logic         clk = 1'b0;
  logic         rst, start, out_ready, busy, out_valid, done;
  logic [191:0] key_in, out_key;
  logic [3:0]   out_step;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [191:0] K_FIPS = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [191:0] K_SEQ  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [191:0] K_ALT  = 192'hffeeddccbbaa99887766554433221100ffeeddccbbaa9988;

  logic [191:0] sexp [9];
  logic [191:0] got_key [9];
  logic [3:0]   got_step [9];

  always #5 clk = ~clk;

  aes192_key_unroll dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_step(out_step),
    .out_key(out_key), .done(done)
  );

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one sequence. Cycle c=0 is the start cycle; sampling happens on negedge.
  task automatic run(input string nm, input logic [191:0] key, input bit prestarted,
                     input int ready_pct, input bit poke, input int abort_at,
                     input bit chain, input logic [191:0] chain_key,
                     output int t_valid, output int t_done, output int n_hs, output int n_unst);
    bit pv, pr;
    logic [191:0] pk;
    logic [3:0] ps;
    t_valid = -1; t_done = -1; n_hs = 0; n_unst = 0;
    pv = 1'b0; pr = 1'b0; pk = '0; ps = '0;
    if (!prestarted) begin
      start  = 1'b1;
      key_in = key;
    end
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = ~key;
    for (int c = 1; c < 400; c++) begin
      out_ready = (int'($urandom_range(99)) < ready_pct);
      start     = poke && (c == 3 || c == 12);
      key_in    = poke ? K_ALT : ~key;
      @(negedge clk);
      if (c == 1) chk({nm, " busy_after_start"}, 192'(busy), 192'(1));
      if (out_valid && t_valid < 0) t_valid = c;
      if (pv && !pr && (!out_valid || out_key !== pk || out_step !== ps)) n_unst++;
      if (abort_at >= 0 && out_valid && out_step == 4'(abort_at)) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        chk({nm, " abort_valid"}, 192'(out_valid), 192'(0));
        chk({nm, " abort_busy"}, 192'(busy), 192'(0));
        repeat (4) begin
          @(negedge clk);
          if (out_valid || busy || done) n_unst++;
        end
        return;
      end
      if (out_valid && out_ready) begin
        if (n_hs < 9) begin
          got_key[n_hs]  = out_key;
          got_step[n_hs] = out_step;
        end
        n_hs++;
      end
      pv = out_valid; pr = out_ready; pk = out_key; ps = out_step;
      if (done) begin
        t_done = c;
        chk({nm, " done_busy"}, 192'(busy), 192'(0));
        chk({nm, " done_valid"}, 192'(out_valid), 192'(0));
        if (chain) begin
          start  = 1'b1;
          key_in = chain_key;
        end
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_chunks(input string nm, input int n);
    for (int i = 0; i < n && i < 9; i++) begin
      chk($sformatf("%s step[%0d]", nm, i), 192'(got_step[i]), 192'(8 - i));
      chk($sformatf("%s key[%0d]", nm, i), got_key[i], sexp[8 - i]);
    end
  endtask

  initial begin
    int tv, td, nh, nu;
    sexp[0] = K_FIPS;
    sexp[1] = 192'hfe0c91f72402f5a5ec12068e6c827f6b0e7a95b95c56fec2;
    sexp[2] = 192'h4db7b4bd69b5411885a74796e92538fde75fad44bb095386;
    sexp[3] = 192'h485af05721efb14fa448f6d94d6dce24aa326360113b30e6;
    sexp[4] = 192'ha25e7ed583b1cf9a27f939436a94f767c0a69407d19da4e1;
    sexp[5] = 192'hec1786eb6fa64971485f703222cb8755e26d135233f0b7b3;
    sexp[6] = 192'h40beeb282f18a2596747d26b458c553ea7e1466c9411f1df;
    sexp[7] = 192'h821f750aad07d753ca4005388fcc5006282d166abc3ce7b5;
    sexp[8] = 192'he98ba06f448c773c8ecc720401002202292d34689511d3dd;

    rst = 1'b1; start = 1'b0; out_ready = 1'b0; key_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 192'(busy), 192'(0));
    chk("reset out_valid", 192'(out_valid), 192'(0));
    chk("reset done", 192'(done), 192'(0));
    chk("reset out_step", 192'(out_step), 192'(0));
    chk("reset out_key", out_key, 192'(0));
    @(posedge clk); #1;

    // Full throughput on the FIPS key
    run("fips", K_FIPS, 1'b0, 100, 1'b0, -1, 1'b0, '0, tv, td, nh, nu);
    chk("fips first_valid", 192'(tv), 192'(9));
    chk("fips done_cycle", 192'(td), 192'(18));
    chk("fips handshakes", 192'(nh), 192'(9));
    check_chunks("fips", nh);
    @(posedge clk); #1;

    // Backpressure at ~30% ready
    run("bp", K_FIPS, 1'b0, 30, 1'b0, -1, 1'b0, '0, tv, td, nh, nu);
    chk("bp first_valid", 192'(tv), 192'(9));
    chk("bp done_seen", 192'(td > 18), 192'(1));
    chk("bp handshakes", 192'(nh), 192'(9));
    chk("bp stall_stable", 192'(nu), 192'(0));
    check_chunks("bp", nh);
    @(posedge clk); #1;

    // Start pulses during FWD and EMIT are ignored
    run("poke", K_FIPS, 1'b0, 100, 1'b1, -1, 1'b0, '0, tv, td, nh, nu);
    chk("poke first_valid", 192'(tv), 192'(9));
    chk("poke done_cycle", 192'(td), 192'(18));
    chk("poke handshakes", 192'(nh), 192'(9));
    check_chunks("poke", nh);
    @(posedge clk); #1;

    // Reset while step 4 is presented
    run("abort", K_FIPS, 1'b0, 100, 1'b0, 4, 1'b0, '0, tv, td, nh, nu);
    chk("abort handshakes", 192'(nh), 192'(4));
    chk("abort stays_idle", 192'(nu), 192'(0));
    check_chunks("abort", nh);
    @(posedge clk); #1;

    // Fresh key after abort; restart in the done cycle with the FIPS key
    run("seq", K_SEQ, 1'b0, 100, 1'b0, -1, 1'b1, K_FIPS, tv, td, nh, nu);
    chk("seq first_valid", 192'(tv), 192'(9));
    chk("seq done_cycle", 192'(td), 192'(18));
    chk("seq handshakes", 192'(nh), 192'(9));
    chk("seq last_step", 192'(got_step[8]), 192'(0));
    chk("seq first_step", 192'(got_step[0]), 192'(8));
    chk("seq step0_key", got_key[8], K_SEQ);

    run("b2b", K_FIPS, 1'b1, 60, 1'b0, -1, 1'b0, '0, tv, td, nh, nu);
    chk("b2b first_valid", 192'(tv), 192'(9));
    chk("b2b handshakes", 192'(nh), 192'(9));
    chk("b2b stall_stable", 192'(nu), 192'(0));
    check_chunks("b2b", nh);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
